exp_series: RTL and testbench

Fixed-point exponential evaluator, the inverse counterpart of the natural-log series unit in the math-function library. It computes e^x for a fractional input x in [0,1) as a truncated Taylor series 1 + Σ x^n/n! using one shared 16×16 fractional multiplier and an 18-bit accumulator. A self-contained controller and a start/done handshake mean the host only loads x and waits. It sits beside the log unit on the same 16-bit operand bus and 18-bit result bus.

---
 rtl/exp_pkg.sv | 26 ++
 rtl/exp_frac_mul.sv | 16 +
 rtl/exp_series.sv | 114 +++++++++++
 tb/tb_exp_series.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared constants and types for the exp_series unit: widths, FSM states,
// the 1/n coefficient table and the fixed-point one constants.
package exp_pkg;

  localparam int OP_W  = 16;
  localparam int ACC_W = 18;

  localparam logic [ACC_W-1:0] E_ONE = 18'h10000;
  // 16'hFFFF stands in for 1.0 because Q0.16 cannot represent it exactly.
  localparam logic [OP_W-1:0]  T_ONE = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_C,
    ACC,
    DONE
  } state_t;

  // Index k holds 1/(k+1) in Q0.16.
  localparam logic [7:0][OP_W-1:0] COEF = {
    16'h2000, 16'h2492, 16'h2AAA, 16'h3333,
    16'h4000, 16'h5555, 16'h8000, 16'hFFFF
  };

endpackage

// File: rtl/exp_frac_mul.sv
// Unsigned 16x16 fractional multiply; returns the upper half of the product
// (truncated, no rounding). Purely combinational.
module exp_frac_mul
  import exp_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic [OP_W-1:0] p
);

  logic [2*OP_W-1:0] full;

  assign full = {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
  assign p    = full[2*OP_W-1:OP_W];

endmodule

// File: rtl/exp_series.sv
// e^x for x in [0,1) as 1 + sum x^n/n!, three cycles per term on one shared
// fractional multiplier. Define EXP_EARLY_EXIT_EN to stop once a term hits zero.
module exp_series
  import exp_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  x_in,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  localparam logic [3:0] N_LAST = 4'(N_TERMS);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   x_q, x_d;
  logic [OP_W-1:0]   t_q, t_d;
  logic [ACC_W-1:0]  e_q, e_d;
  logic [3:0]        n_q, n_d;
  logic [ACC_W-1:0]  result_q, result_d;

  logic [2:0]        c_idx;
  logic [OP_W-1:0]   mul_b;
  logic [OP_W-1:0]   prod;
  logic [ACC_W-1:0]  acc_sum;

  assign c_idx   = n_q[2:0] - 3'd1;
  assign mul_b   = (state_q == MUL_C) ? COEF[c_idx] : x_q;
  assign acc_sum = e_q + {2'b00, t_q};

  exp_frac_mul u_mul (
    .a (t_q),
    .b (mul_b),
    .p (prod)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    t_d      = t_q;
    e_d      = e_q;
    n_d      = n_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          t_d     = T_ONE;
          e_d     = E_ONE;
          n_d     = 4'd1;
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        t_d     = prod;
        state_d = MUL_C;
      end
      MUL_C: begin
        t_d     = prod;
        state_d = ACC;
`ifdef EXP_EARLY_EXIT_EN
        // A zero term means every later term is zero too; E is already final.
        if (prod == '0) begin
          state_d  = DONE;
          result_d = e_q;
        end
`endif
      end
      ACC: begin
        e_d = acc_sum;
        if (n_q == N_LAST) begin
          state_d  = DONE;
          result_d = acc_sum;
        end else begin
          n_d     = n_q + 4'd1;
          state_d = MUL_X;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      t_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      t_q      <= t_d;
      e_q      <= e_d;
      n_q      <= n_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_exp_series.sv
// Self-checking bench for exp_series: a vector table over two instances
// (N_TERMS=8 and N_TERMS=1) plus directed multi-cycle sequences.
module tb_exp_series;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        start_s;
  logic [15:0] x_s;

  logic        start8, start1;
  logic        busy8, done8, busy1, done1;
  logic [17:0] res8, res1;
  logic        busy_s, done_s;
  logic [17:0] res_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign start8 = start_s & ~sel;
  assign start1 = start_s & sel;
  assign busy_s = sel ? busy1 : busy8;
  assign done_s = sel ? done1 : done8;
  assign res_s  = sel ? res1  : res8;

  exp_series #(.N_TERMS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x_in(x_s),
    .busy(busy8), .done(done8), .result(res8)
  );

  exp_series #(.N_TERMS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .x_in(x_s),
    .busy(busy1), .done(done1), .result(res1)
  );

  typedef struct {
    logic        sel;
    logic [15:0] x;
    logic [17:0] approx;
    logic [17:0] tol;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] coef(input int n);
    case (n)
      1: coef = 16'hFFFF;
      2: coef = 16'h8000;
      3: coef = 16'h5555;
      4: coef = 16'h4000;
      5: coef = 16'h3333;
      6: coef = 16'h2AAA;
      7: coef = 16'h2492;
      default: coef = 16'h2000;
    endcase
  endfunction

  // Bit-exact truncating reference plus expected start-to-done latency.
  task automatic model(input logic [15:0] x, input int nt, output logic [17:0] e, output int lat);
    logic [15:0] t;
    logic [31:0] p;
    t   = 16'hFFFF;
    e   = 18'h10000;
    lat = 3 * nt + 1;
    for (int n = 1; n <= nt; n++) begin
      p = {16'h0, t} * {16'h0, x};
      t = p[31:16];
      p = {16'h0, t} * {16'h0, coef(n)};
      t = p[31:16];
`ifdef EXP_EARLY_EXIT_EN
      if (t == 16'h0) begin
        lat = 3 * (n - 1) + 3;
        break;
      end
`endif
      e = e + {2'b00, t};
    end
  endtask

  // One start pulse; returns result at the done cycle and the cycle count.
  task automatic run(input logic s, input logic [15:0] x, input logic scramble,
                     output logic [17:0] res, output int lat);
    logic [17:0] prev;
    logic        stable;
    @(negedge clk);
    sel     = s;
    start_s = 1'b1;
    x_s     = x;
    #1;
    prev = res_s;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    lat     = 0;
    stable  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (done_s) begin
        lat = k;
        break;
      end
      if (res_s !== prev) stable = 1'b0;
      if (scramble) x_s = 16'($urandom);
      @(negedge clk);
    end
    res = res_s;
    check("result_stable_while_busy", stable, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done_s, 1'b0);
    check("busy_low_after_done", busy_s, 1'b0);
  endtask

  initial begin
    logic [17:0] res, exp_res;
    int          lat, exp_lat, d, pulses, last_k;

    vecs[0] = '{1'b0, 16'h0000, 18'h10000, 18'h0};
    vecs[1] = '{1'b0, 16'h8000, 18'h1A612, 18'h10};
    vecs[2] = '{1'b0, 16'hFFFF, 18'h2B7E1, 18'h20};
    vecs[3] = '{1'b0, 16'h4000, 18'h148B5, 18'h10};
    vecs[4] = '{1'b0, 16'h1000, 18'h11082, 18'h10};
    vecs[5] = '{1'b1, 16'h4000, 18'h13FFE, 18'h0};
    vecs[6] = '{1'b1, 16'h0000, 18'h10000, 18'h0};

    rst = 1'b1; sel = 1'b0; start_s = 1'b0; x_s = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_res8", res8, 18'h0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_res1", res1, 18'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(vecs[i].sel, vecs[i].x, 1'b0, res, lat);
      model(vecs[i].x, vecs[i].sel ? 1 : 8, exp_res, exp_lat);
      check($sformatf("vec%0d_result", i), res, exp_res);
      check($sformatf("vec%0d_latency", i), lat, exp_lat);
      d = int'(res) - int'(vecs[i].approx);
      if (d < 0) d = -d;
      check($sformatf("vec%0d_near_ref_diff_%0d", i, d), d <= int'(vecs[i].tol), 1'b1);
    end

    // x_in wiggling while busy must not leak into the result.
    run(1'b0, 16'h8000, 1'b1, res, lat);
    model(16'h8000, 8, exp_res, exp_lat);
    check("scramble_result", res, exp_res);

    // start raised in the DONE cycle is ignored, taken the next IDLE cycle.
    run(1'b1, 16'h4000, 1'b0, res, lat);
    @(negedge clk);
    sel = 1'b1; start_s = 1'b1; x_s = 16'h8000;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done1) begin lat = k; break; end
    end
    @(negedge clk);
    check("start_in_done_ignored", busy1, 1'b0);
    @(negedge clk);
    start_s = 1'b0;
    check("start_after_done_taken", busy1, 1'b1);
    for (int k = 0; k < 10 && !done1; k++) @(negedge clk);
    model(16'h8000, 1, exp_res, exp_lat);
    check("start_after_done_result", res1, exp_res);
    @(negedge clk);

    // Continuous start: one run every 26 cycles.
    model(16'hFFFF, 8, exp_res, exp_lat);
    sel = 1'b0; x_s = 16'hFFFF; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pulses = 0; last_k = 0;
    for (int k = 1; k <= 100; k++) begin
      if (done8) begin
        pulses++;
        check($sformatf("held_res_%0d", pulses), res8, exp_res);
        if (pulses == 1) check("held_first_latency", k, 25);
        else check($sformatf("held_spacing_%0d", pulses), k - last_k, 26);
        last_k = k;
        if (pulses == 3) begin
          start_s = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    check("held_pulse_count", pulses, 3);
    repeat (2) @(negedge clk);
    check("held_idle_after_release", busy8, 1'b0);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    sel = 1'b0; x_s = 16'h8000; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy8, 1'b0);
    check("midrst_done", done8, 1'b0);
    check("midrst_result", res8, 18'h0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 16'h4000, 1'b0, res, lat);
    model(16'h4000, 8, exp_res, exp_lat);
    check("post_rst_result", res, exp_res);
    check("post_rst_latency", lat, exp_lat);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
